// File: rtl/cpu_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// cpu_fetch_sequencer_if : byte-wide fetch bus, redirect/halt control and
//                          decoder valid/ready handshake for the fetch sequencer
// Revision: 1.0
// ============================================================================
interface cpu_fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int WORD_BYTES = 2
) ();
  logic [ADDR_WIDTH-1:0]            address_bus;
  logic [DATA_WIDTH-1:0]            data_bus;
  logic                             r;
  logic                             mem_ready;
  logic                             redirect;
  logic [ADDR_WIDTH-1:0]            redirect_pc;
  logic                             halt_req;
  logic                             instr_valid;
  logic                             instr_ready;
  logic [DATA_WIDTH*WORD_BYTES-1:0] instr_word;
  logic [ADDR_WIDTH-1:0]            instr_pc;
  logic                             halted;
  logic                             bus_fault;

  modport master (
    output address_bus, r, instr_valid, instr_word, instr_pc, halted, bus_fault,
    input  data_bus, mem_ready, redirect, redirect_pc, halt_req, instr_ready
  );

  modport slave (
    input  address_bus, r, instr_valid, instr_word, instr_pc, halted, bus_fault,
    output data_bus, mem_ready, redirect, redirect_pc, halt_req, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/cpu_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// cpu_fetch_sequencer : multi-beat instruction fetch with wait-state timeout,
//                       branch redirect and halt at instruction boundaries
// Revision: 1.0
// ============================================================================
module cpu_fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    WORD_BYTES = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    MAX_WAIT   = 15
) (
  input  wire logic              clk,
  input  wire logic              reset,
  cpu_fetch_sequencer_if.master  fetch
);

  localparam int BEAT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORD_BYTES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [2:0] {
    START  = 3'd0,
    BUS    = 3'd1,
    VALID  = 3'd2,
    HALTED = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t                           r_state;
  logic [ADDR_WIDTH-1:0]            r_pc;
  logic [BEAT_W-1:0]                r_beat;
  logic [WAIT_W-1:0]                r_wait_cnt;
  logic [DATA_WIDTH*WORD_BYTES-1:0] r_word;
  logic [ADDR_WIDTH-1:0]            r_instr_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= START;
      r_pc       <= RESET_PC;
      r_beat     <= '0;
      r_wait_cnt <= '0;
      r_word     <= '0;
      r_instr_pc <= RESET_PC;
    end else begin
      unique case (r_state)
        START: begin
          if (fetch.redirect) begin
            r_pc    <= fetch.redirect_pc;
            r_state <= START;
          end else if (fetch.halt_req) begin
            r_state <= HALTED;
          end else begin
            r_instr_pc <= r_pc;
            r_beat     <= '0;
            r_wait_cnt <= '0;
            r_state    <= BUS;
          end
        end
        BUS: begin
          // A redirect abandons the partial word; the stale slots are simply overwritten later.
          if (fetch.redirect) begin
            r_pc    <= fetch.redirect_pc;
            r_state <= START;
          end else if (fetch.mem_ready) begin
            r_word[int'(r_beat)*DATA_WIDTH +: DATA_WIDTH] <= fetch.data_bus;
            r_pc       <= r_pc + 1'b1;
            r_wait_cnt <= '0;
            if (r_beat == BEAT_LAST) r_state <= VALID;
            else                     r_beat  <= r_beat + 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (MAX_WAIT != 0 && r_wait_cnt == WAIT_LAST) r_state <= FAULT;
          end
        end
        VALID: begin
          if (fetch.redirect) begin
            r_pc    <= fetch.redirect_pc;
            r_state <= START;
          end else if (fetch.instr_ready) begin
            r_state <= START;
          end
        end
        HALTED: begin
          if (fetch.redirect) r_pc <= fetch.redirect_pc;
          if (!fetch.halt_req) r_state <= START;
        end
        FAULT: begin
          r_state <= FAULT;
        end
        default: begin
          r_state <= START;
        end
      endcase
    end
  end

  // Status outputs come straight from the state register, so they never glitch on inputs.
  assign fetch.address_bus = r_pc;
  assign fetch.r           = (r_state == BUS);
  assign fetch.instr_valid = (r_state == VALID);
  assign fetch.halted      = (r_state == HALTED);
  assign fetch.bus_fault   = (r_state == FAULT);
  assign fetch.instr_word  = r_word;
  assign fetch.instr_pc    = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cpu_fetch_sequencer : directed stimulus with a transaction-level model
//                          checked every cycle on two parameterisations
// Revision: 1.0
// ============================================================================
module tb_cpu_fetch_sequencer;

  logic clk;
  logic reset;
  logic armed;
  int   n_checks;
  int   n_fail;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_pc    [2];
  int          wait_run  [2];
  logic        exp_fault [2];
  int          acc_cnt   [2];

  cpu_fetch_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WORD_BYTES(2)) bus0 ();
  cpu_fetch_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WORD_BYTES(3)) bus1 ();

  cpu_fetch_sequencer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .WORD_BYTES(2), .RESET_PC(16'h0000), .MAX_WAIT(15)
  ) dut0 (.clk(clk), .reset(reset), .fetch(bus0));

  cpu_fetch_sequencer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .WORD_BYTES(3), .RESET_PC(16'hFFFF), .MAX_WAIT(15)
  ) dut1 (.clk(clk), .reset(reset), .fetch(bus1));

  assign bus0.data_bus = mem[bus0.address_bus];
  assign bus1.data_bus = mem[bus1.address_bus];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: each word is the next WORD_BYTES memory bytes from the expected PC,
  // the PC advances by a word per accept and jumps on redirect; a run of MAX_WAIT stalls faults.
  task automatic model_cmp(input int id, input int wb, input logic [15:0] rst_pc,
                           input logic rst_i, input logic [15:0] addr, input logic rd,
                           input logic rdy, input logic redir, input logic [15:0] rpc,
                           input logic vld, input logic irdy, input logic [23:0] word,
                           input logic [15:0] ipc, input logic hlt, input logic flt);
    logic [23:0] w;
    logic [15:0] a;
    chk($sformatf("m%0d_fault", id), flt, exp_fault[id]);
    chk($sformatf("m%0d_onehot", id), (int'(rd) + int'(vld) + int'(hlt) + int'(flt)) <= 1, 1);
    if (vld) begin
      w = '0;
      for (int k = 0; k < wb; k++) begin
        a = exp_pc[id] + 16'(k);
        w[k*8 +: 8] = mem[a];
      end
      chk($sformatf("m%0d_instr_pc", id), ipc, exp_pc[id]);
      chk($sformatf("m%0d_instr_word", id), word, w);
    end
    if (rd) begin
      a = addr - exp_pc[id];
      chk($sformatf("m%0d_addr_window", id), int'(a) < wb, 1);
    end
    if (rst_i) begin
      exp_pc[id] = rst_pc;
      wait_run[id] = 0;
      exp_fault[id] = 1'b0;
    end else if (!flt) begin
      if (vld && irdy) acc_cnt[id]++;
      if (redir) begin
        exp_pc[id] = rpc;
        wait_run[id] = 0;
      end else if (vld && irdy) begin
        exp_pc[id] = exp_pc[id] + 16'(wb);
      end else if (rd && !rdy) begin
        wait_run[id]++;
        if (wait_run[id] == 15) exp_fault[id] = 1'b1;
      end else begin
        wait_run[id] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      model_cmp(0, 2, 16'h0000, reset, bus0.address_bus, bus0.r, bus0.mem_ready, bus0.redirect,
                bus0.redirect_pc, bus0.instr_valid, bus0.instr_ready, 24'(bus0.instr_word),
                bus0.instr_pc, bus0.halted, bus0.bus_fault);
      model_cmp(1, 3, 16'hFFFF, reset, bus1.address_bus, bus1.r, bus1.mem_ready, bus1.redirect,
                bus1.redirect_pc, bus1.instr_valid, bus1.instr_ready, bus1.instr_word,
                bus1.instr_pc, bus1.halted, bus1.bus_fault);
    end
  end

  task automatic wait_valid(input int id, input int exp_edges, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!((id == 0) ? bus0.instr_valid : bus1.instr_valid) && n < 40);
    chk(name, n, exp_edges);
  endtask

  initial begin
    int acc_before;
    n_checks = 0;
    n_fail   = 0;
    armed    = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 7) + ((i >> 8) * 13));
    mem[0]     = 8'h34;
    mem[1]     = 8'h12;
    mem[65535] = 8'hAB;
    for (int i = 0; i < 2; i++) begin
      exp_pc[i] = (i == 0) ? 16'h0000 : 16'hFFFF;
      wait_run[i] = 0;
      exp_fault[i] = 1'b0;
      acc_cnt[i] = 0;
    end
    reset = 1'b1;
    bus0.mem_ready = 1'b1; bus0.redirect = 1'b0; bus0.redirect_pc = '0;
    bus0.halt_req  = 1'b0; bus0.instr_ready = 1'b0;
    bus1.mem_ready = 1'b1; bus1.redirect = 1'b0; bus1.redirect_pc = '0;
    bus1.halt_req  = 1'b0; bus1.instr_ready = 1'b0;

    tick();
    armed = 1'b1;
    tick();
    chk("rst_valid", bus0.instr_valid, 0);
    chk("rst_r", bus0.r, 0);
    chk("rst_halted", bus0.halted, 0);
    chk("rst_fault", bus0.bus_fault, 0);
    chk("rst_word", bus0.instr_word, 16'h0000);
    chk("rst_ipc", bus0.instr_pc, 16'h0000);
    chk("rst_addr", bus0.address_bus, 16'h0000);
    chk("rst_ipc_w3", bus1.instr_pc, 16'hFFFF);

    // Zero-wait fetch from reset, then hold the word under backpressure.
    reset = 1'b0;
    wait_valid(0, 3, "first_valid_latency");
    chk("first_word", bus0.instr_word, 16'h1234);
    chk("first_pc", bus0.instr_pc, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", bus0.instr_valid, 1);
      chk("bp_word", bus0.instr_word, 16'h1234);
      chk("bp_pc", bus0.instr_pc, 16'h0000);
      chk("bp_r", bus0.r, 0);
      chk("bp_addr", bus0.address_bus, 16'h0002);
    end

    // Three-beat word across the address wrap.
    chk("wrap_valid", bus1.instr_valid, 1);
    chk("wrap_pc", bus1.instr_pc, 16'hFFFF);
    chk("wrap_word", bus1.instr_word, 24'h1234AB);
    bus1.instr_ready = 1'b1;
    tick();
    bus1.instr_ready = 1'b0;
    chk("wrap_next_addr", bus1.address_bus, 16'h0002);
    wait_valid(1, 4, "wrap_next_latency");
    chk("wrap_next_pc", bus1.instr_pc, 16'h0002);
    chk("wrap_next_word", bus1.instr_word, 24'h1C150E);

    bus0.instr_ready = 1'b1;
    wait_valid(0, 4, "throughput");
    bus0.instr_ready = 1'b0;
    chk("second_pc", bus0.instr_pc, 16'h0002);
    chk("second_word", bus0.instr_word, 16'h150E);

    // Three wait cycles on beat 1.
    bus0.instr_ready = 1'b1;
    tick();
    bus0.instr_ready = 1'b0;
    tick();
    tick();
    bus0.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws3_r", bus0.r, 1);
      chk("ws3_valid", bus0.instr_valid, 0);
    end
    bus0.mem_ready = 1'b1;
    tick();
    chk("ws3_valid_now", bus0.instr_valid, 1);
    chk("ws3_word", bus0.instr_word, 16'h231C);
    chk("ws3_pc", bus0.instr_pc, 16'h0004);

    // Redirect after beat 0 of a fetch at 0x0010.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus0.redirect = 1'b1; bus0.redirect_pc = 16'h0010;
    tick();
    bus0.redirect = 1'b0;
    tick();
    chk("redir_fetch_pc", bus0.instr_pc, 16'h0010);
    tick();
    chk("redir_beat1_addr", bus0.address_bus, 16'h0011);
    bus0.redirect = 1'b1; bus0.redirect_pc = 16'h0100;
    tick();
    bus0.redirect = 1'b0;
    chk("redir_drop_valid", bus0.instr_valid, 0);
    chk("redir_addr", bus0.address_bus, 16'h0100);
    wait_valid(0, 3, "redir_latency");
    chk("redir_pc", bus0.instr_pc, 16'h0100);
    chk("redir_word", bus0.instr_word, 16'h140D);

    // Redirect together with accept: consumed exactly once.
    acc_before = acc_cnt[0];
    bus0.instr_ready = 1'b1; bus0.redirect = 1'b1; bus0.redirect_pc = 16'h0200;
    tick();
    bus0.instr_ready = 1'b0; bus0.redirect = 1'b0;
    chk("redir_acc_valid", bus0.instr_valid, 0);
    chk("redir_acc_once", acc_cnt[0] - acc_before, 1);
    wait_valid(0, 3, "redir_acc_latency");
    chk("redir_acc_pc", bus0.instr_pc, 16'h0200);
    chk("redir_acc_word", bus0.instr_word, 16'h211A);

    // Redirect without accept drops the word.
    acc_before = acc_cnt[0];
    bus0.redirect = 1'b1; bus0.redirect_pc = 16'h0010;
    tick();
    bus0.redirect = 1'b0;
    chk("redir_noacc_valid", bus0.instr_valid, 0);
    wait_valid(0, 3, "redir_noacc_latency");
    chk("redir_noacc_none", acc_cnt[0] - acc_before, 0);
    chk("redir_noacc_word", bus0.instr_word, 16'h7770);

    // Halt at the boundary, redirect while halted, then release.
    bus0.halt_req = 1'b1; bus0.instr_ready = 1'b1;
    tick();
    bus0.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_halted", bus0.halted, 1);
      chk("halt_r", bus0.r, 0);
    end
    bus0.redirect = 1'b1; bus0.redirect_pc = 16'h0200;
    tick();
    bus0.redirect = 1'b0;
    chk("halt_redir_halted", bus0.halted, 1);
    chk("halt_redir_addr", bus0.address_bus, 16'h0200);
    bus0.halt_req = 1'b0;
    wait_valid(0, 4, "halt_release_latency");
    chk("halt_release_pc", bus0.instr_pc, 16'h0200);

    // Fourteen stalls then ready: beat still accepted, no fault.
    bus0.instr_ready = 1'b1;
    tick();
    bus0.instr_ready = 1'b0;
    bus0.mem_ready = 1'b0;
    tick();
    repeat (14) tick();
    chk("ws14_fault", bus0.bus_fault, 0);
    chk("ws14_r", bus0.r, 1);
    bus0.mem_ready = 1'b1;
    tick();
    tick();
    chk("ws14_valid", bus0.instr_valid, 1);
    chk("ws14_pc", bus0.instr_pc, 16'h0202);

    // Fifteen stalls: sticky fault that ignores every control input.
    bus0.instr_ready = 1'b1;
    tick();
    bus0.instr_ready = 1'b0;
    bus0.mem_ready = 1'b0;
    tick();
    repeat (14) tick();
    chk("to_pre_fault", bus0.bus_fault, 0);
    tick();
    chk("to_fault", bus0.bus_fault, 1);
    chk("to_r", bus0.r, 0);
    bus0.redirect = 1'b1; bus0.redirect_pc = 16'h0300;
    bus0.halt_req = 1'b1; bus0.instr_ready = 1'b1; bus0.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_sticky", bus0.bus_fault, 1);
      chk("to_sticky_valid", bus0.instr_valid, 0);
      chk("to_sticky_halted", bus0.halted, 0);
    end
    bus0.redirect = 1'b0; bus0.halt_req = 1'b0; bus0.instr_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk("to_reset_fault", bus0.bus_fault, 0);
    chk("to_reset_pc", bus0.instr_pc, 16'h0000);
    reset = 1'b0;
    wait_valid(0, 3, "to_reset_latency");
    chk("to_reset_word", bus0.instr_word, 16'h1234);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
